// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port 64-bit data memory.
// Port 0 is the CPU load/store stage; port 1 is the loader/debug (DMA) master.
// Grants are combinational. Read data is registered and returned one cycle after the grant.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned AW       = 64,
  parameter int unsigned DW       = 64,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_data_out
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          hold_ok;
  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic          in_range;

  // Grant selection from the previous owner; grants are suppressed while in reset.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    hold_ok = (hold_q < HW'(MAX_HOLD));
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          // Tie: the port not granted last wins.
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      StOwn0: begin
        if (req0 && (hold_ok || !req1)) gnt0 = 1'b1;
        else if (req1)                  gnt1 = 1'b1;
      end
      StOwn1: begin
        if (req1 && (hold_ok || !req0)) gnt1 = 1'b1;
        else if (req0)                  gnt0 = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Memory drive from the granted port; all zero when nothing is granted.
  always_comb begin
    any_gnt     = gnt0 || gnt1;
    sel_we      = gnt1 ? we1 : we0;
    sel_addr    = gnt1 ? addr1 : addr0;
    in_range    = (sel_addr < AW'(DEPTH));
    mem_address = any_gnt ? sel_addr : '0;
    mem_data_in = any_gnt ? (gnt1 ? wdata1 : wdata0) : '0;
    mem_read    = any_gnt && !sel_we;
    mem_write   = any_gnt && sel_we && in_range;
  end

  // Next owner, fairness counter and registered responses.
  always_comb begin
    state_d   = StIdle;
    last_d    = last_q;
    hold_d    = '0;
    if (gnt0) begin
      state_d = StOwn0;
      last_d  = 1'b0;
    end else if (gnt1) begin
      state_d = StOwn1;
      last_d  = 1'b1;
    end
    // hold counts repeat grants to the same owner, saturating at MAX_HOLD.
    if ((gnt0 && state_q == StOwn0) || (gnt1 && state_q == StOwn1)) begin
      hold_d = hold_ok ? hold_q + 1'b1 : hold_q;
    end

    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    err0_d    = gnt0 && !in_range;
    err1_d    = gnt1 && !in_range;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    // Out-of-range reads return zero rather than whatever the memory presents.
    if (rvalid0_d) rdata0_d = in_range ? mem_data_out : '0;
    if (rvalid1_d) rdata1_d = in_range ? mem_data_out : '0;
  end

  // State and response registers; async reset cancels any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      hold_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a response scoreboard.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH    = 128;
  localparam int unsigned AW       = 64;
  localparam int unsigned DW       = 64;
  localparam int unsigned MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_read, mem_write;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct packed {
    logic          rv;
    logic          er;
    logic [DW-1:0] d;
  } resp_t;

  resp_t q0[$];
  resp_t q1[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .DW      (DW),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .err0        (err0),
    .err1        (err1),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_data_out(mem_data_out)
  );

  // Combinational-read memory; out-of-range addresses present junk the arbiter must hide.
  assign mem_data_out = (mem_address < 64'd128) ? mem[mem_address[6:0]] : 64'hBAD0_BAD0_BAD0_BAD0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'h1000 + 64'(i);
    mem[3] = 64'd5;
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_address[6:0]] <= mem_data_in;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string p, input resp_t e, input logic rv, input logic er,
                            input logic [DW-1:0] d);
    chk({"sb_rvalid", p}, 64'(rv), 64'(e.rv));
    chk({"sb_err", p}, 64'(er), 64'(e.er));
    if (e.rv) chk({"sb_rdata", p}, d, e.d);
  endtask

  function automatic resp_t expect_for(input logic we, input logic [AW-1:0] a);
    resp_t e;
    e = '0;
    if (a < 64'(DEPTH)) begin
      if (!we) e = '{rv: 1'b1, er: 1'b0, d: ref_mem[a[6:0]]};
    end else begin
      e = '{rv: !we, er: 1'b1, d: '0};
    end
    return e;
  endfunction

  // Scoreboard: check last cycle's responses, then record this cycle's transfers.
  initial begin
    resp_t e;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'h1000 + 64'(i);
    ref_mem[3] = 64'd5;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        chk("rst_rvalid0", 64'(rvalid0), 64'd0);
        chk("rst_rvalid1", 64'(rvalid1), 64'd0);
        chk("rst_err0", 64'(err0), 64'd0);
        chk("rst_err1", 64'(err1), 64'd0);
      end else begin
        e = (q0.size() > 0) ? q0.pop_front() : '0;
        check_resp("0", e, rvalid0, err0, rdata0);
        e = (q1.size() > 0) ? q1.pop_front() : '0;
        check_resp("1", e, rvalid1, err1, rdata1);
        if (req0 && gnt0) begin
          e = expect_for(we0, addr0);
          if (e.rv || e.er) q0.push_back(e);
          if (we0 && addr0 < 64'(DEPTH)) ref_mem[addr0[6:0]] = wdata0;
        end
        if (req1 && gnt1) begin
          e = expect_for(we1, addr1);
          if (e.rv || e.er) q1.push_back(e);
          if (we1 && addr1 < 64'(DEPTH)) ref_mem[addr1[6:0]] = wdata1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0;  addr1 = '0;  wdata0 = '0; wdata1 = '0;
  endtask

  initial begin
    int exp_seq [24] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    int c0 = 0;
    int c1 = 0;

    // 1. Reset with both ports trying to write.
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 64'd1; addr1 = 64'd2; wdata0 = 64'hFFFF; wdata1 = 64'hEEEE;
    repeat (3) step();
    chk("rst_gnt0", 64'(gnt0), 64'd0);
    chk("rst_gnt1", 64'(gnt1), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_mem1", mem[1], 64'h1001);
    chk("rst_mem2", mem[2], 64'h1002);
    idle_inputs();
    rst_n = 1'b1;

    // 2. Single read by port 0.
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd3;
    #1;
    chk("rd_gnt0", 64'(gnt0), 64'd1);
    chk("rd_gnt1", 64'(gnt1), 64'd0);
    chk("rd_mem_read", 64'(mem_read), 64'd1);
    chk("rd_mem_address", mem_address, 64'd3);
    step();
    idle_inputs();
    chk("rd_rvalid0", 64'(rvalid0), 64'd1);
    chk("rd_rdata0", rdata0, 64'd5);
    chk("rd_err0", 64'(err0), 64'd0);
    step();
    chk("rd_pulse_end", 64'(rvalid0), 64'd0);
    chk("rd_rdata0_held", rdata0, 64'd5);

    // 3. Port 1 writes then reads back the same address.
    req1 = 1'b1; we1 = 1'b1; addr1 = 64'd10; wdata1 = 64'hDEAD;
    #1;
    chk("wr_gnt1", 64'(gnt1), 64'd1);
    chk("wr_mem_write", 64'(mem_write), 64'd1);
    chk("wr_mem_data_in", mem_data_in, 64'hDEAD);
    step();
    we1 = 1'b0;
    #1;
    chk("rb_gnt1", 64'(gnt1), 64'd1);
    chk("wr_no_resp", 64'(rvalid1 | err1), 64'd0);
    step();
    idle_inputs();
    chk("rb_rvalid1", 64'(rvalid1), 64'd1);
    chk("rb_rdata1", rdata1, 64'hDEAD);
    chk("rb_err1", 64'(err1), 64'd0);

    // 4. Contention: each port issues 12 reads.
    for (int i = 0; i < 24; i++) begin
      step();
      req0 = (c0 < 12); we0 = 1'b0; addr0 = 64'(20 + c0);
      req1 = (c1 < 12); we1 = 1'b0; addr1 = 64'(40 + c1);
      #1;
      chk($sformatf("rr_gnt0_%0d", i), 64'(gnt0), 64'(exp_seq[i] == 0));
      chk($sformatf("rr_gnt1_%0d", i), 64'(gnt1), 64'(exp_seq[i] == 1));
      if (gnt0) c0++;
      if (gnt1) c1++;
    end
    chk("rr_count0", 64'(c0), 64'd12);
    chk("rr_count1", 64'(c1), 64'd12);
    step();
    idle_inputs();

    // 5. Out-of-range write then read on port 0.
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd200; wdata0 = 64'h77;
    #1;
    chk("oor_wr_gnt0", 64'(gnt0), 64'd1);
    chk("oor_wr_mem_write", 64'(mem_write), 64'd0);
    step();
    we0 = 1'b0;
    #1;
    chk("oor_wr_err0", 64'(err0), 64'd1);
    chk("oor_wr_rvalid0", 64'(rvalid0), 64'd0);
    chk("oor_rd_gnt0", 64'(gnt0), 64'd1);
    chk("oor_rd_mem_read", 64'(mem_read), 64'd1);
    step();
    idle_inputs();
    chk("oor_rd_rvalid0", 64'(rvalid0), 64'd1);
    chk("oor_rd_rdata0", rdata0, 64'd0);
    chk("oor_rd_err0", 64'(err0), 64'd1);
    chk("oor_mem72", mem[72], 64'h1048);

    // 6. Reset in the cycle after a port 1 read grant.
    step();
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd5;
    #1;
    chk("mr_gnt1", 64'(gnt1), 64'd1);
    step();
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd6;
    #1;
    chk("mr_rvalid1", 64'(rvalid1), 64'd0);
    chk("mr_err1", 64'(err1), 64'd0);
    chk("mr_gnt_in_rst", 64'({gnt0, gnt1}), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_tie_gnt0", 64'(gnt0), 64'd1);
    chk("mr_tie_gnt1", 64'(gnt1), 64'd0);
    step();
    idle_inputs();
    step();
    step();

    chk("sb_q0_empty", 64'(q0.size()), 64'd0);
    chk("sb_q1_empty", 64'(q1.size()), 64'd0);
    chk("final_mem10", mem[10], 64'hDEAD);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
